// File: rtl/panda_load_sequencer.sv
// -----------------------------------------------------------------------------
// panda_load_sequencer
//
// Walks a programmable list of memory regions, issues one stream request per
// eligible region and writes the returned words into the selected accelerator
// memory through the PANDA memory demux. An output-tile loop re-loads the
// regions flagged in tile_mask with a source address advanced by one region
// length per tile.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   start_i              start pulse, only honoured in IDLE
//   clear_i              synchronous abort back to IDLE
//   region_en_i          per-region enable
//   tile_mask_i          regions re-loaded on tiles > 0
//   nb_tile_i            tile count (0 behaves as 1)
//   dmem_addr_i          flattened byte source base per region
//   len_i                flattened region length in words
//   amem_addr_i          flattened destination word base per region
//   req_*                stream request channel towards the source streamer
//   in_*                 returned data words
//   mem_*                registered write port towards the memory demux
//   busy_o, done_o       activity flag and one-cycle completion pulse
//   tile_o               current tile index
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// are both high. req_valid_o never drops and its payload never changes while
// it waits for req_ready_i; in_ready_o is high for the whole STREAM state and
// does not depend on in_valid_i.
// -----------------------------------------------------------------------------
module panda_load_sequencer #(
  parameter int NB_REGION = 7,
  parameter int SEL_W     = $clog2(NB_REGION + 1),
  parameter int ADDR_W    = 32,
  parameter int AADDR_W   = 16,
  parameter int LEN_W     = 16,
  parameter int DATA_W    = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          clear_i,
  input  logic [NB_REGION-1:0]          region_en_i,
  input  logic [NB_REGION-1:0]          tile_mask_i,
  input  logic [7:0]                    nb_tile_i,
  input  logic [NB_REGION*ADDR_W-1:0]   dmem_addr_i,
  input  logic [NB_REGION*LEN_W-1:0]    len_i,
  input  logic [NB_REGION*AADDR_W-1:0]  amem_addr_i,
  output logic                          req_valid_o,
  input  logic                          req_ready_i,
  output logic [ADDR_W-1:0]             req_addr_o,
  output logic [LEN_W-1:0]              req_len_o,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [DATA_W-1:0]             in_data_i,
  output logic [SEL_W-1:0]              mem_sel_o,
  output logic                          mem_wr_en_o,
  output logic [AADDR_W-1:0]            mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [7:0]                    tile_o
);

  localparam logic [SEL_W-1:0] NULL_SEL       = SEL_W'(NB_REGION);
  localparam int               BYTES_PER_WORD = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECT    = 3'd1,
    S_REQ       = 3'd2,
    S_STREAM    = 3'd3,
    S_TERMINATE = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Configuration snapshot taken on the accepted start.
  logic [NB_REGION-1:0]         cfg_en_q,   cfg_en_d;
  logic [NB_REGION-1:0]         cfg_mask_q, cfg_mask_d;
  logic [7:0]                   cfg_nb_q,   cfg_nb_d;
  logic [NB_REGION*ADDR_W-1:0]  cfg_dmem_q, cfg_dmem_d;
  logic [NB_REGION*LEN_W-1:0]   cfg_len_q,  cfg_len_d;
  logic [NB_REGION*AADDR_W-1:0] cfg_amem_q, cfg_amem_d;

  // Walk state.
  logic [SEL_W-1:0]   ptr_q,       ptr_d;
  logic [7:0]         tile_q,      tile_d;
  logic [SEL_W-1:0]   region_q,    region_d;
  logic [ADDR_W-1:0]  req_addr_q,  req_addr_d;
  logic [LEN_W-1:0]   req_len_q,   req_len_d;
  logic [AADDR_W-1:0] amem_base_q, amem_base_d;
  logic [LEN_W-1:0]   cnt_q,       cnt_d;

  // Registered memory write port.
  logic               mem_wr_en_q, mem_wr_en_d;
  logic [SEL_W-1:0]   mem_sel_q,   mem_sel_d;
  logic [AADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

  // Region search results.
  logic [NB_REGION-1:0] nz_vec;
  logic [NB_REGION-1:0] elig_vec;
  logic                 found;
  logic [SEL_W-1:0]     found_idx;
  logic [ADDR_W-1:0]    sel_dmem;
  logic [LEN_W-1:0]     sel_len;
  logic [AADDR_W-1:0]   sel_amem;
  logic [8:0]           nb_eff;
  logic                 more_tiles;
  logic                 last_word;
  logic                 in_hs;

  // ---------------------------------------------------------------------------
  // Region search: lowest eligible index at or above ptr_q. Tiles after the
  // first only consider masked regions. The loop runs downwards so the last
  // hit, i.e. the lowest index, wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    nz_vec    = '0;
    found     = 1'b0;
    found_idx = '0;
    sel_dmem  = '0;
    sel_len   = '0;
    sel_amem  = '0;
    for (int i = 0; i < NB_REGION; i++) begin
      nz_vec[i] = (cfg_len_q[i*LEN_W +: LEN_W] != '0);
    end
    elig_vec = cfg_en_q & nz_vec & ((tile_q == 8'd0) ? {NB_REGION{1'b1}} : cfg_mask_q);
    for (int i = NB_REGION - 1; i >= 0; i--) begin
      if (elig_vec[i] && (i >= int'(ptr_q))) begin
        found     = 1'b1;
        found_idx = SEL_W'(i);
        sel_dmem  = cfg_dmem_q[i*ADDR_W +: ADDR_W];
        sel_len   = cfg_len_q[i*LEN_W +: LEN_W];
        sel_amem  = cfg_amem_q[i*AADDR_W +: AADDR_W];
      end
    end
    nb_eff     = (cfg_nb_q == 8'd0) ? 9'd1 : {1'b0, cfg_nb_q};
    // Another tile only makes sense if some region would actually be re-loaded.
    more_tiles = (({1'b0, tile_q} + 9'd1) < nb_eff) && (|(cfg_en_q & cfg_mask_q & nz_vec));
    last_word  = (cnt_q == (req_len_q - LEN_W'(1)));
    in_hs      = (state_q == S_STREAM) && in_valid_i;
  end

  // ---------------------------------------------------------------------------
  // State register and all datapath flops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cfg_en_q    <= '0;
      cfg_mask_q  <= '0;
      cfg_nb_q    <= '0;
      cfg_dmem_q  <= '0;
      cfg_len_q   <= '0;
      cfg_amem_q  <= '0;
      ptr_q       <= '0;
      tile_q      <= '0;
      region_q    <= '0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      amem_base_q <= '0;
      cnt_q       <= '0;
      mem_wr_en_q <= 1'b0;
      mem_sel_q   <= NULL_SEL;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cfg_en_q    <= cfg_en_d;
      cfg_mask_q  <= cfg_mask_d;
      cfg_nb_q    <= cfg_nb_d;
      cfg_dmem_q  <= cfg_dmem_d;
      cfg_len_q   <= cfg_len_d;
      cfg_amem_q  <= cfg_amem_d;
      ptr_q       <= ptr_d;
      tile_q      <= tile_d;
      region_q    <= region_d;
      req_addr_q  <= req_addr_d;
      req_len_q   <= req_len_d;
      amem_base_q <= amem_base_d;
      cnt_q       <= cnt_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (found)           state_d = S_REQ;
        else if (more_tiles) state_d = S_SELECT;
        else                 state_d = S_TERMINATE;
      end
      S_REQ: begin
        if (req_ready_i) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (in_valid_i && last_word) state_d = S_SELECT;
      end
      S_TERMINATE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (clear_i) state_d = S_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Datapath next values.
  // ---------------------------------------------------------------------------
  always_comb begin
    cfg_en_d    = cfg_en_q;
    cfg_mask_d  = cfg_mask_q;
    cfg_nb_d    = cfg_nb_q;
    cfg_dmem_d  = cfg_dmem_q;
    cfg_len_d   = cfg_len_q;
    cfg_amem_d  = cfg_amem_q;
    ptr_d       = ptr_q;
    tile_d      = tile_q;
    region_d    = region_q;
    req_addr_d  = req_addr_q;
    req_len_d   = req_len_q;
    amem_base_d = amem_base_q;
    cnt_d       = cnt_q;
    mem_wr_en_d = 1'b0;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cfg_en_d   = region_en_i;
          cfg_mask_d = tile_mask_i;
          cfg_nb_d   = nb_tile_i;
          cfg_dmem_d = dmem_addr_i;
          cfg_len_d  = len_i;
          cfg_amem_d = amem_addr_i;
          ptr_d      = '0;
          tile_d     = '0;
        end
      end
      S_SELECT: begin
        if (found) begin
          region_d    = found_idx;
          // Each tile advances the source by one full region of bytes.
          req_addr_d  = sel_dmem + ADDR_W'(tile_q) * ADDR_W'(sel_len) * ADDR_W'(BYTES_PER_WORD);
          req_len_d   = sel_len;
          amem_base_d = sel_amem;
        end else if (more_tiles) begin
          tile_d = tile_q + 8'd1;
          ptr_d  = '0;
        end else begin
          mem_sel_d = NULL_SEL;
        end
      end
      S_REQ: begin
        if (req_ready_i) cnt_d = '0;
      end
      S_STREAM: begin
        if (in_hs) begin
          mem_wr_en_d = 1'b1;
          mem_sel_d   = region_q;
          mem_addr_d  = amem_base_q + AADDR_W'(cnt_q);
          mem_wdata_d = in_data_i;
          cnt_d       = cnt_q + LEN_W'(1);
          if (last_word) ptr_d = region_q + SEL_W'(1);
        end
      end
      default: begin
      end
    endcase

    // Abort: everything except the configuration snapshot returns to reset
    // values, including a write that would have issued next cycle.
    if (clear_i) begin
      ptr_d       = '0;
      tile_d      = '0;
      region_d    = '0;
      req_addr_d  = '0;
      req_len_d   = '0;
      amem_base_d = '0;
      cnt_d       = '0;
      mem_wr_en_d = 1'b0;
      mem_sel_d   = NULL_SEL;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_valid_o = (state_q == S_REQ);
    in_ready_o  = (state_q == S_STREAM);
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_TERMINATE);
    req_addr_o  = req_addr_q;
    req_len_o   = req_len_q;
    mem_wr_en_o = mem_wr_en_q;
    mem_sel_o   = mem_sel_q;
    mem_addr_o  = mem_addr_q;
    mem_wdata_o = mem_wdata_q;
    tile_o      = tile_q;
  end

endmodule

// File: doc/panda_load_sequencer.md
# panda_load_sequencer

Parametrised load sequencer for the PANDA accelerator wrapper: walks a programmable list of memory regions (config, instruction, LUT, sparsity, activation, weight-conv, weight-FC, …), issues one stream request per region, and writes the returned words into the selected accelerator memory through the memory demux. It generalises the fixed seven-region load with three additions: an arbitrary region count, per-region skip of zero-length regions, and an output-tile loop that re-loads a masked subset of regions with advancing source addresses. It sits between the register file and controller on one side, and the source streamer and the PANDA memory demux on the other.

## Interface
Clock is `clk_i`; reset `rst_i` is synchronous and active-high.

Parameters:
- NB_REGION, 7, number of regions; region index i drives mem_sel value i
- SEL_W, $clog2(NB_REGION+1), width of mem_sel; value NB_REGION means null select
- ADDR_W, 32, byte address width, data side
- AADDR_W, 16, word address width, accelerator memory side
- LEN_W, 16, region length in words
- DATA_W, 32, word width; byte stride per word is DATA_W/8

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  start pulse; sampled only in IDLE
- clear_i  in  1  synchronous abort to IDLE
- region_en_i  in  NB_REGION  per-region enable
- tile_mask_i  in  NB_REGION  regions reloaded per tile
- nb_tile_i  in  8  tile count; 0 is treated as 1
- dmem_addr_i  in  NB_REGION*ADDR_W  flattened source base, region i at [i*ADDR_W +: ADDR_W]
- len_i  in  NB_REGION*LEN_W  flattened region length in words
- amem_addr_i  in  NB_REGION*AADDR_W  flattened destination base
- req_valid_o / req_ready_i  out/in  1/1  stream request handshake
- req_addr_o  out  ADDR_W  request source address
- req_len_o  out  LEN_W  request length
- in_valid_i / in_ready_o  in/out  1/1  data handshake
- in_data_i  in  DATA_W  incoming word
- mem_sel_o  out  SEL_W  demux select
- mem_wr_en_o  out  1  write strobe
- mem_addr_o  out  AADDR_W  destination word address
- mem_wdata_o  out  DATA_W  write data
- busy_o  out  1  high outside IDLE
- done_o  out  1  one-cycle completion pulse
- tile_o  out  8  current tile index

## Operation
- All outputs reset to 0, except mem_sel_o, which resets to NB_REGION. All configuration inputs are latched on the accepted start.
- FSM states: IDLE, SELECT, REQ, STREAM, TERMINATE.
- IDLE: on start_i, latch the configuration and set ptr=0, tile=0, then go to SELECT. A start_i in any other state is ignored.
- SELECT: find the lowest index ≥ ptr that is eligible.
  - Tile 0: eligible means enabled and len≠0.
  - Tile > 0: eligible additionally requires tile_mask set.
  - Found: register the region, go to REQ.
  - None found and tile+1 < max(nb_tile,1) and (en & mask & len≠0) is nonzero: tile++, ptr=0, stay in SELECT.
  - Otherwise: go to TERMINATE.
- REQ: hold req_valid_o with req_addr_o = dmem + tile·len·(DATA_W/8) (mod 2^ADDR_W) and req_len_o = len until req_ready_i, then go to STREAM with word counter = 0.
- STREAM: in_ready_o = 1. Each accepted word registers a write on the next cycle:
  - mem_wr_en_o = 1, mem_sel_o = region, mem_addr_o = amem + counter (mod 2^AADDR_W), mem_wdata_o = in_data_i.
  - After word len−1 is accepted: ptr = region+1, go to SELECT.
- TERMINATE: done_o = 1 for one cycle, then go to IDLE. mem_sel_o returns to NB_REGION.
- clear_i (any state): next cycle IDLE. In-flight register write is dropped, no done_o, outputs at reset values.
- rst_i has the same effect as clear_i and also clears the latched configuration.

## Timing
- start at cycle t: SELECT at t+1, req_valid_o at t+2 at the earliest.
- All regions skipped: TERMINATE at t+2, done_o at t+2, IDLE at t+3.
- Data latency: handshake at cycle c gives mem_wr_en_o at c+1. One word per cycle is sustained.
- Last word accepted at c: SELECT at c+1; with no further region, done_o at c+2.
- Between regions, in_ready_o is low for at least 2 cycles (SELECT, REQ).
- req_valid_o, once raised, stays high and its payload is stable until the handshake.
- mem_sel_o holds the last region until the next region's first write or TERMINATE.

## Test plan
- Enable regions 0 and 4 with len 2 and 3, amem 0x10/0x40; start; stream 5 words → writes sel0@0x10,0x11 then sel4@0x40..0x42; done_o 2 cycles after the last handshake.
- Region 2 enabled with len=0 and all others disabled → no req_valid_o; done_o exactly 2 cycles after start.
- nb_tile=3, region 4 masked (len 4, dmem 0x1000) plus region 0 unmasked → region 0 loaded once; region 4 requested at 0x1000, 0x1010, 0x1020; tile_o steps 0,1,2.
- Hold req_ready_i low 5 cycles and toggle in_valid_i 1/0 → req payload stable; writes only on handshakes; addresses contiguous.
- Assert clear_i mid-STREAM → IDLE next cycle; no further mem_wr_en_o, no done_o; a new start runs normally.
- amem=0xFFFE, len 3 → mem_addr_o sequence 0xFFFE, 0xFFFF, 0x0000; start_i pulsed while busy → ignored.
